// File: rtl/forthsuper_pkg.sv
// Shared types for the ForthSuper stack engine: command codes, controller states
// and the default geometry of a stack instance.
package forthsuper_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_PICK = 2'b11
    } stack_ops;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        PICK_RD
    } ds_state_e;

    localparam int DSZ_DEF   = 32;
    localparam int SSZ_DEF   = 6;
    localparam int DEPTH_DEF = 2**SSZ_DEF;

    // Total capacity in cells (s0 + s1 + RAM) for a given depth exponent.
    function automatic int stack_depth(input int ssz);
        return 2**ssz;
    endfunction

endpackage

// File: rtl/forthsuper_sdpram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port
// with a single cycle of read latency. Written so that it maps onto block RAM.
module forthsuper_sdpram #(
    parameter int DSZ   = 32,
    parameter int ASZ   = 6,
    parameter int WORDS = 2**ASZ
) (
    input  logic           clk,
    input  logic           we,
    input  logic [ASZ-1:0] wa,
    input  logic [DSZ-1:0] wd,
    input  logic [ASZ-1:0] ra,
    output logic [DSZ-1:0] rd
);

    logic [DSZ-1:0] mem [0:WORDS-1];

    // Write when enabled; read address is always sampled, data appears next cycle.
    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= wd;
        rd <= mem[ra];
    end

endmodule

// File: rtl/forthsuper_dstack.sv
// ForthSuper stack engine. TOS (s0) and NOS (s1) live in registers; deeper cells
// live in a block RAM at address sp-1-depth. Deep POP refills s1 from RAM and
// deep PICK fetches from RAM, each costing one extra cycle with ready low.
module forthsuper_dstack
    import forthsuper_pkg::*;
#(
    parameter int DSZ = 32,
    parameter int SSZ = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     op,
    input  logic [DSZ-1:0] vi,
    input  logic [SSZ-1:0] pick_n,
    input  logic           err_clr,
    output logic           ready,
    output logic [DSZ-1:0] s0,
    output logic [DSZ-1:0] s1,
    output logic [SSZ:0]   sp,
    output logic           empty,
    output logic           full,
    output logic           ovf,
    output logic           udf
);

    localparam int           DEPTH  = stack_depth(SSZ);
    localparam logic [SSZ:0] SP_MAX = (SSZ+1)'(DEPTH);

    ds_state_e      state;
    stack_ops       cmd;
    logic           pick_ok, pick_deep;
    logic           do_push, do_pop, do_pick, push_now;
    logic           set_ovf, set_udf, we;
    logic [DSZ-1:0] push_val, rd;
    logic [SSZ-1:0] wa, ra;

    assign cmd   = stack_ops'(op);
    assign ready = (state == IDLE);
    assign empty = (sp == '0);
    assign full  = (sp == SP_MAX);

    // Legality of the presented command; errors never change the stack.
    assign pick_ok   = ({1'b0, pick_n} < sp);
    assign pick_deep = (pick_n >= SSZ'(2));
    assign do_push   = ready && cmd == OP_PUSH && !full;
    assign do_pop    = ready && cmd == OP_POP && !empty;
    assign do_pick   = ready && cmd == OP_PICK && !full && pick_ok;
    assign set_ovf   = ready && (cmd == OP_PUSH || cmd == OP_PICK) && full;
    assign set_udf   = ready && ((cmd == OP_POP && empty) || (cmd == OP_PICK && !pick_ok));

    // Anything that lands a new TOS this cycle: PUSH, DUP/OVER, or the second
    // half of a deep PICK.
    assign push_now  = do_push || (do_pick && !pick_deep) || state == PICK_RD;

    // Select the value being pushed onto the top of the stack.
    always_comb begin
        push_val = vi;
        if (state == PICK_RD)
            push_val = rd;
        else if (cmd == OP_PICK)
            push_val = (pick_n == '0) ? s0 : s1;
    end

    // A push spills the old s1 into RAM once two cells are already held in
    // registers. Reads happen only from IDLE, writes never coincide with them.
    assign we = rst_n && push_now && (sp >= (SSZ+1)'(2));
    assign wa = SSZ'(sp - (SSZ+1)'(2));
    assign ra = (cmd == OP_POP) ? SSZ'(sp - (SSZ+1)'(3))
                                : SSZ'(sp - (SSZ+1)'(1) - {1'b0, pick_n});

    forthsuper_sdpram #(
        .DSZ   (DSZ),
        .ASZ   (SSZ),
        .WORDS (DEPTH - 2)
    ) u_ram (
        .clk (clk),
        .we  (we),
        .wa  (wa),
        .wd  (s1),
        .ra  (ra),
        .rd  (rd)
    );

    // Controller: register stack top, occupancy, sticky flags and state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sp    <= '0;
            s0    <= '0;
            s1    <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            // A new error outranks a simultaneous clear.
            ovf <= set_ovf ? 1'b1 : (err_clr ? 1'b0 : ovf);
            udf <= set_udf ? 1'b1 : (err_clr ? 1'b0 : udf);

            if (push_now) begin
                s0 <= push_val;
                s1 <= s0;
                sp <= sp + 1'b1;
            end else if (do_pop) begin
                s0 <= s1;
                sp <= sp - 1'b1;
                if (sp < (SSZ+1)'(3))
                    s1 <= '0;
            end

            case (state)
                IDLE: begin
                    if (do_pop && sp >= (SSZ+1)'(3))
                        state <= REFILL;
                    else if (do_pick && pick_deep)
                        state <= PICK_RD;
                end
                REFILL: begin
                    s1    <= rd;
                    state <= IDLE;
                end
                PICK_RD: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_forthsuper_dstack.sv
// Scoreboarded bench for forthsuper_dstack (DSZ=32, SSZ=3). The driver updates a
// queue-based stack model and pushes the expected post-op view; the monitor
// compares whenever the DUT is ready again with an expectation outstanding.
module tb_forthsuper_dstack;
    import forthsuper_pkg::*;

    localparam int DSZ = 32;
    localparam int SSZ = 3;
    localparam int DEP = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     op = 2'b00;
    logic [DSZ-1:0] vi = '0;
    logic [SSZ-1:0] pick_n = '0;
    logic           err_clr = 1'b0;
    logic           ready, empty, full, ovf, udf;
    logic [DSZ-1:0] s0, s1;
    logic [SSZ:0]   sp;

    forthsuper_dstack #(.DSZ(DSZ), .SSZ(SSZ)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .vi(vi), .pick_n(pick_n),
        .err_clr(err_clr), .ready(ready), .s0(s0), .s1(s1), .sp(sp),
        .empty(empty), .full(full), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] s0;
        logic [31:0] s1;
        int          sp;
        logic        ovf;
        logic        udf;
        int          lat;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl[$];     // index 0 = top of stack
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    function automatic exp_t snap(input int lat);
        exp_t e;
        e.s0  = (mdl.size() > 0) ? mdl[0] : 32'd0;
        e.s1  = (mdl.size() > 1) ? mdl[1] : 32'd0;
        e.sp  = mdl.size();
        e.ovf = m_ovf;
        e.udf = m_udf;
        e.lat = lat;
        e.cyc = cyc;
        return e;
    endfunction

    // Monitor: an op has completed when ready returns with something outstanding.
    exp_t me;
    always @(negedge clk) begin
        if (ready === 1'b1 && sb.size() > 0) begin
            me = sb.pop_front();
            chk("sp",    32'(sp),    32'(me.sp));
            chk("s0",    s0,         me.s0);
            chk("s1",    s1,         me.s1);
            chk("ovf",   32'(ovf),   32'(me.ovf));
            chk("udf",   32'(udf),   32'(me.udf));
            chk("empty", 32'(empty), 32'(me.sp == 0));
            chk("full",  32'(full),  32'(me.sp == DEP));
            chk("latency", 32'(cyc - me.cyc), 32'(me.lat));
        end
    end

    // Wait (bounded) until the DUT is idle and all expectations are checked.
    task automatic wait_idle();
        int guard = 0;
        while (!(ready === 1'b1 && sb.size() == 0)) begin
            @(negedge clk); #1;
            guard++;
            if (guard > 20) begin
                checks++; errors++;
                $display("FAIL idle_timeout: ready=%0b pending=%0d expected ready=1 pending=0", ready, sb.size());
                sb.delete();
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; op = 2'b00; err_clr = 1'b0;
        sb.delete(); mdl.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        sb.push_back(snap(1));
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Present one op, update the model from the stack rules, queue the result.
    task automatic issue(input logic [1:0] o, input logic [31:0] v, input int pn, input logic clr);
        int          n, lat;
        logic        so, su;
        logic [31:0] pv;
        wait_idle();
        op = o; vi = v; pick_n = pn[SSZ-1:0]; err_clr = clr;
        n = mdl.size(); lat = 1; so = 1'b0; su = 1'b0;
        case (o)
            2'b01: if (n == DEP) so = 1'b1; else mdl.push_front(v);
            2'b10: if (n == 0) su = 1'b1;
                   else begin void'(mdl.pop_front()); if (n >= 3) lat = 2; end
            2'b11: begin
                if (n == DEP) so = 1'b1;
                if (pn >= n)  su = 1'b1;
                if (!so && !su) begin
                    pv = mdl[pn];
                    mdl.push_front(pv);
                    if (pn >= 2) lat = 2;
                end
            end
            default: ;
        endcase
        m_ovf = so ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_udf = su ? 1'b1 : (clr ? 1'b0 : m_udf);
        sb.push_back(snap(lat));
        @(negedge clk); #1;
        op = 2'b00; err_clr = 1'b0;
    endtask

    initial begin
        do_reset();

        // PUSH 1..4 back to back, then pops down to one cell.
        for (int i = 1; i <= 4; i++) issue(2'b01, 32'(i), 0, 1'b0);
        for (int i = 0; i < 3; i++)  issue(2'b10, 0, 0, 1'b0);
        issue(2'b10, 0, 0, 1'b0);

        // Fill, overflow, clear.
        for (int i = 10; i <= 17; i++) issue(2'b01, 32'(i), 0, 1'b0);
        issue(2'b01, 32'd99, 0, 1'b0);
        issue(2'b00, 0, 0, 1'b1);

        // Pop to 6, deep PICK 4, DUP, then PICKs while full.
        issue(2'b10, 0, 0, 1'b0);
        issue(2'b10, 0, 0, 1'b0);
        issue(2'b11, 0, 4, 1'b0);
        issue(2'b11, 0, 0, 1'b0);
        issue(2'b11, 0, 0, 1'b0);
        issue(2'b11, 0, 7, 1'b0);
        issue(2'b00, 0, 0, 1'b1);

        // Drain, underflow, clear coinciding with a new underflow.
        for (int i = 0; i < 8; i++) issue(2'b10, 0, 0, 1'b0);
        issue(2'b10, 0, 0, 1'b0);
        issue(2'b10, 0, 0, 1'b1);
        issue(2'b00, 0, 0, 1'b1);

        // PICK beyond occupancy, then OVER.
        issue(2'b01, 32'hA1, 0, 1'b0);
        issue(2'b01, 32'hA2, 0, 1'b0);
        issue(2'b11, 0, 2, 1'b0);
        issue(2'b11, 0, 1, 1'b0);
        issue(2'b00, 0, 0, 1'b1);

        // Random traffic, push-biased so the stack visits both ends.
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [1:0] o;
            r = int'($urandom_range(0, 9));
            o = (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : (r < 9) ? 2'b11 : 2'b00;
            issue(o, $urandom, int'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
        end

        // Reset while a deep PICK is in its read cycle.
        wait_idle();
        do_reset();
        for (int i = 1; i <= 5; i++) issue(2'b01, 32'(20 + i), 0, 1'b0);
        wait_idle();
        op = 2'b11; pick_n = 3'd3;
        @(negedge clk); #1;
        op = 2'b00;
        chk("pickrd_ready", 32'(ready), 32'd0);
        do_reset();
        issue(2'b01, 32'd5, 0, 1'b0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/forthsuper_dstack.md
Name: forthsuper_dstack

Overview:
- Parametrised Forth data/return stack engine; successor to the single-entry `ss_io` stack model.
- Keeps TOS (`s0`) and NOS (`s1`) in registers and the rest of the stack in a simple dual-port synchronous RAM.
- Supports the full `stack_ops` set, including PICK, with a ready handshake, overflow/underflow detection and occupancy flags.
- Sits between the ForthSuper execution unit and block RAM; one instance serves as the data stack and one as the return stack.

Parameters:
- DSZ, 32, data width of each stack cell.
- SSZ, 6, depth exponent; stack capacity DEPTH = 2**SSZ cells total, counting `s0`, `s1` and RAM cells.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- op  in  2  `stack_ops` command: NOP=00, PUSH=01, POP=10, PICK=11. Sampled only when ready=1.
- vi  in  DSZ  push data, sampled with PUSH.
- pick_n  in  SSZ  PICK depth index; 0 = `s0`, 1 = `s1`, k = k-th cell below TOS.
- err_clr  in  1  clears the `ovf`/`udf` sticky flags.
- ready  out  1  block accepts an op this cycle.
- s0  out  DSZ  top of stack (registered).
- s1  out  DSZ  next of stack (registered).
- sp  out  SSZ+1  occupancy, 0..DEPTH.
- empty  out  1  sp==0.
- full  out  1  sp==DEPTH.
- ovf  out  1  sticky; set by PUSH or PICK when full.
- udf  out  1  sticky; set by POP when empty, or by PICK with pick_n>=sp.

Behaviour:
Reset (rst_n=0 at a clk edge):
- state=IDLE, sp=0, s0=0, s1=0, ovf=0, udf=0, ready=1.
- Any in-flight REFILL or PICK_RD is aborted with no stack change.

Storage mapping:
- Cell at depth k>=2 lives at RAM address sp-1-k. RAM holds DEPTH-2 cells.
- RAM has one write port and one registered read port with 1-cycle read latency.

States: IDLE, REFILL, PICK_RD. ready=1 only in IDLE. Ops presented while ready=0 are ignored; the master holds op until ready.

PUSH (IDLE, sp<DEPTH), completes in 1 cycle:
- s0<=vi, s1<=s0, sp<=sp+1.
- If sp>=2: ram[sp-2]<=s1.
- Stays in IDLE.

POP (IDLE, sp>=1):
- s0<=s1, sp<=sp-1.
- If sp>=3: issue RAM read at addr sp-3, go to REFILL.
- Otherwise: s1<=0, stay in IDLE.
- The popped value is `s0` as presented in the cycle POP is accepted.

REFILL (1 cycle): s1<=rdata; go to IDLE.

PICK (IDLE, pick_n<sp, sp<DEPTH):
- pick_n=0: push `s0` in 1 cycle (DUP).
- pick_n=1: push `s1` in 1 cycle (OVER).
- pick_n>=2: issue RAM read at addr sp-1-pick_n, go to PICK_RD.

PICK_RD (1 cycle): perform a PUSH of rdata, including the ram[sp-2]<=s1 write; go to IDLE.

Error cases (no state change, stay in IDLE, no RAM write):
- PUSH or PICK when full: set ovf.
- POP when empty: set udf.
- PICK with pick_n>=sp: set udf.
- If sp==DEPTH and pick_n>=sp, both ovf and udf are set.

Flags:
- ovf/udf persist until err_clr.
- If err_clr coincides with a new error, the set wins.

Hazards:
- No cycle both writes and reads RAM, so no same-address hazard exists.
- Latency: PUSH, DUP, OVER and shallow POP take 1 cycle; deep POP and deep PICK take 2 cycles each.

Outputs:
- All outputs are registered except empty, full and ready, which decode sp and state.
- sp arithmetic is SSZ+1 bits; it never wraps because the guards above block it.

Decomposition:
- Package `forthsuper_pkg` holds:
  - the `stack_ops` enum, moved out of the interface file;
  - the state enum `ds_state_e` {IDLE, REFILL, PICK_RD};
  - the localparam DEPTH = 2**SSZ.
- Sub-module `forthsuper_sdpram` #(DSZ, ASZ=SSZ): simple dual-port sync RAM (we, wa, wd, ra, rd) that infers EBR.
- The `ss_io` interface is updated to carry ready, s1, pick_n and the flags. The `push`/`pop` tasks wait on ready.

Test Plan (SSZ=3, DEPTH=8, DSZ=32):
- Reset, then PUSH 1,2,3,4 on consecutive cycles -> sp=4, s0=4, s1=3, ready stays 1, ram[0]=1, ram[1]=2.
- From sp=4, POP -> same edge: s0=3, sp=3; next cycle ready=0 (REFILL); the following cycle s1=2, ready=1. POP twice more -> sp=1, s0=1, s1=0 with no REFILL on the last POP.
- Fill to sp=8 with 10..17, then PUSH 99 -> ovf=1, sp=8, s0=17 unchanged. Pulse err_clr -> ovf=0.
- With 10..17 pushed, POP to sp=6 (s0=15), then PICK pick_n=4 -> 2 cycles, ready=0 in the second; s0=11, s1=15, sp=7. PICK pick_n=0 -> s0=11, s1=11, sp=8.
- Empty stack: POP -> udf=1, sp=0. With sp=2, PICK pick_n=2 -> udf=1, no change. err_clr asserted in the same cycle as a new POP on empty -> udf stays 1.
- Assert rst_n=0 during PICK_RD -> sp=0, s0=s1=0, state IDLE, no push; next PUSH 5 -> sp=1, s0=5.
